control_sequencer: RTL and testbench

- Hardwired control unit that issues the per-T-state datapath control signals for fetch and execute. Today the testbench stimulus produces these signals by hand.
- Sits beside the datapath. Reads the IR contents and drives every enable, select, Gra/Grb/BAout and ALU-opcode input, one T-state per clock.
- Memory accesses use a ready handshake, so variable-latency memory is tolerated.

---
 rtl/control_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the single-bus datapath. Walks fetch (T0-T2),
// decode (T3) and the per-opcode execute states (T4-T7), issuing one T-state of
// datapath controls per clock. Memory accesses in T1 (fetch), T6 (ld) and
// T7 (st) wait on mem_ready, so memory latency can vary.
//
// Ports
//   clk                  system clock, rising-edge active
//   reset                asynchronous, active-high reset
//   IR_Data[31:0]        instruction register; opcode in [31:27]
//   mem_ready            memory finished the current read/write
//   PC_enable .. r_enable register load enables
//   read, write          memory strobes (read also steers memory into the MDR)
//   Gra, Grb, BAout      register select/encode controls
//   PC_select .. r_select bus source selects
//   alu_instruction[4:0] ALU opcode
//   halted               high while in HALT
//   illegal_op           one-cycle pulse in T3 for an unrecognised opcode
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] ALU_AND = 5'b00101,
  parameter logic [4:0] ALU_OR  = 5'b00110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_Data,
  input  logic        mem_ready,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        r_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        BAout,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic        r_select,
  output logic [4:0]  alu_instruction,
  output logic        halted,
  output logic        illegal_op
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_opcode;   // opcode captured in T3 for the execute states
  logic [4:0] w_ir_op;
  logic       w_mem_op;   // ld or st: address-calculation path through T5

  // Only the opcode field steers sequencing; operand fields go to the datapath.
  logic       w_unused_ir;
  assign w_unused_ir = ^IR_Data[26:0];

  assign w_ir_op  = IR_Data[31:27];
  assign w_mem_op = (r_opcode == OP_LD) || (r_opcode == OP_ST);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_T0;
      r_opcode <= 5'b00000;
    end else begin
      r_state <= w_next;
      if (r_state == S_T3) r_opcode <= w_ir_op;
    end
  end

  // NOTE: every output and w_next gets a default before the case so that no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    w_next              = r_state;
    PC_enable           = 1'b0;
    PC_increment_enable = 1'b0;
    IR_enable           = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    r_enable            = 1'b0;
    read                = 1'b0;
    write               = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    BAout               = 1'b0;
    PC_select           = 1'b0;
    Z_LO_select         = 1'b0;
    MDR_select          = 1'b0;
    c_select            = 1'b0;
    r_select            = 1'b0;
    alu_instruction     = 5'b00000;
    halted              = 1'b0;
    illegal_op          = 1'b0;

    // Outputs are forced low for as long as reset is held, so an abandoned
    // instruction cannot issue a partial write-back during reset.
    if (!reset) begin
      unique case (r_state)
        S_T0: begin
          PC_select  = 1'b1;
          MAR_enable = 1'b1;
          w_next     = S_T1;
        end
        S_T1: begin
          read       = 1'b1;
          MDR_enable = 1'b1;
          // PC bumps only on the completing cycle: one increment per fetch.
          if (mem_ready) begin
            PC_increment_enable = 1'b1;
            w_next              = S_T2;
          end
        end
        S_T2: begin
          MDR_select = 1'b1;
          IR_enable  = 1'b1;
          w_next     = S_T3;
        end
        S_T3: begin
          // IR loaded at the end of T2, so IR_Data is the new instruction here.
          unique case (w_ir_op)
            OP_LD, OP_LDI, OP_ST: begin
              Grb      = 1'b1;
              BAout    = 1'b1;
              Y_enable = 1'b1;
              w_next   = S_T4;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
              Grb      = 1'b1;
              r_select = 1'b1;
              Y_enable = 1'b1;
              w_next   = S_T4;
            end
            OP_NOP:  w_next = S_T0;
            OP_HALT: w_next = S_HALT;
            default: begin
              illegal_op = 1'b1;
              w_next     = S_T0;
            end
          endcase
        end
        S_T4: begin
          c_select = 1'b1;
          Z_enable = 1'b1;
          unique case (r_opcode)
            OP_ANDI: alu_instruction = ALU_AND;
            OP_ORI:  alu_instruction = ALU_OR;
            default: alu_instruction = ALU_ADD;
          endcase
          w_next = S_T5;
        end
        S_T5: begin
          Z_LO_select = 1'b1;
          if (w_mem_op) begin
            MAR_enable = 1'b1;
            w_next     = S_T6;
          end else begin
            Gra      = 1'b1;
            r_enable = 1'b1;
            w_next   = S_T0;
          end
        end
        S_T6: begin
          MDR_enable = 1'b1;
          if (r_opcode == OP_ST) begin
            // read stays low so the MDR loads the store data from the bus.
            Gra      = 1'b1;
            r_select = 1'b1;
            w_next   = S_T7;
          end else begin
            read = 1'b1;
            if (mem_ready) w_next = S_T7;
          end
        end
        S_T7: begin
          if (r_opcode == OP_ST) begin
            write = 1'b1;
            if (mem_ready) w_next = S_T0;
          end else begin
            MDR_select = 1'b1;
            Gra        = 1'b1;
            r_enable   = 1'b1;
            w_next     = S_T0;
          end
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: w_next = S_T0;
      endcase
    end else begin
      w_next = S_T0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_Data;
  logic        mem_ready;
  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
  logic MAR_enable, MDR_enable, r_enable, read, write, Gra, Grb, BAout;
  logic PC_select, Z_LO_select, MDR_select, c_select, r_select;
  logic [4:0] alu_instruction;
  logic halted, illegal_op;

  control_sequencer dut (
    .clk(clk), .reset(reset), .IR_Data(IR_Data), .mem_ready(mem_ready),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .r_enable(r_enable),
    .read(read), .write(write), .Gra(Gra), .Grb(Grb), .BAout(BAout),
    .PC_select(PC_select), .Z_LO_select(Z_LO_select), .MDR_select(MDR_select),
    .c_select(c_select), .r_select(r_select), .alu_instruction(alu_instruction),
    .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Packed control word: one bit per control, ALU code in [6:2].
  localparam logic [24:0] PCE  = 25'd1 << 24;
  localparam logic [24:0] PCI  = 25'd1 << 23;
  localparam logic [24:0] IRE  = 25'd1 << 22;
  localparam logic [24:0] YE   = 25'd1 << 21;
  localparam logic [24:0] ZE   = 25'd1 << 20;
  localparam logic [24:0] MARE = 25'd1 << 19;
  localparam logic [24:0] MDRE = 25'd1 << 18;
  localparam logic [24:0] RE   = 25'd1 << 17;
  localparam logic [24:0] RD   = 25'd1 << 16;
  localparam logic [24:0] WR   = 25'd1 << 15;
  localparam logic [24:0] GRA  = 25'd1 << 14;
  localparam logic [24:0] GRB  = 25'd1 << 13;
  localparam logic [24:0] BAO  = 25'd1 << 12;
  localparam logic [24:0] PCS  = 25'd1 << 11;
  localparam logic [24:0] ZLS  = 25'd1 << 10;
  localparam logic [24:0] MDRS = 25'd1 << 9;
  localparam logic [24:0] CS   = 25'd1 << 8;
  localparam logic [24:0] RS   = 25'd1 << 7;
  localparam logic [24:0] ALU3 = 25'd3 << 2;   // add
  localparam logic [24:0] ALU5 = 25'd5 << 2;   // and
  localparam logic [24:0] ALU6 = 25'd6 << 2;   // or
  localparam logic [24:0] HLT  = 25'd1 << 1;
  localparam logic [24:0] ILL  = 25'd1;
  localparam logic [24:0] NONE = 25'd0;

  // Fetch-state expectations with mem_ready high.
  localparam logic [24:0] E_T0 = PCS | MARE;
  localparam logic [24:0] E_T1 = RD | MDRE | PCI;
  localparam logic [24:0] E_T2 = MDRS | IRE;

  localparam logic [31:0] IR_LDI  = 32'h0880_0005;
  localparam logic [31:0] IR_LD   = 32'h0080_0010;
  localparam logic [31:0] IR_ST   = 32'h1080_0010;
  localparam logic [31:0] IR_ADDI = 32'h6080_0003;
  localparam logic [31:0] IR_ANDI = 32'h6880_0003;
  localparam logic [31:0] IR_ORI  = 32'h7080_0003;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_BAD  = 32'hF800_0000;

  typedef struct {
    logic [31:0] ir;
    logic        mr;
    logic [24:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [24:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [24:0] ctl_word();
    return {PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
            MAR_enable, MDR_enable, r_enable, read, write, Gra, Grb, BAout,
            PC_select, Z_LO_select, MDR_select, c_select, r_select,
            alu_instruction, halted, illegal_op};
  endfunction

  // Compare the current outputs against the oldest queued expectation.
  task automatic check(input string name);
    logic [24:0] got, exp;
    got = ctl_word();
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one T-state's inputs (called just after a falling edge), sample
  // 1 ns later, then wait for the next falling edge.
  task automatic step(input logic [31:0] ir, input logic mr,
                      input logic [24:0] exp, input string name);
    IR_Data   = ir;
    mem_ready = mr;
    exp_q.push_back(exp);
    #1;
    check(name);
    @(negedge clk);
  endtask

  task automatic add(input logic [31:0] ir, input logic mr,
                     input logic [24:0] exp, input string name);
    vec_t v;
    v.ir = ir; v.mr = mr; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [31:0] ir, input string tag);
    add(ir, 1'b1, E_T0, {tag, "_T0"});
    add(ir, 1'b1, E_T1, {tag, "_T1"});
    add(ir, 1'b1, E_T2, {tag, "_T2"});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // ---- vector table, mem_ready tied high ----
    add_fetch(IR_LDI, "ldi");
    add(IR_LDI, 1'b1, GRB | BAO | YE,   "ldi_T3");
    add(IR_LDI, 1'b1, CS | ZE | ALU3,   "ldi_T4");
    add(IR_LDI, 1'b1, ZLS | GRA | RE,   "ldi_T5");
    add_fetch(IR_ADDI, "addi");
    add(IR_ADDI, 1'b1, GRB | RS | YE,   "addi_T3");
    add(IR_ADDI, 1'b1, CS | ZE | ALU3,  "addi_T4");
    add(IR_ADDI, 1'b1, ZLS | GRA | RE,  "addi_T5");
    add_fetch(IR_ANDI, "andi");
    add(IR_ANDI, 1'b1, GRB | RS | YE,   "andi_T3");
    add(IR_ANDI, 1'b1, CS | ZE | ALU5,  "andi_T4");
    add(IR_ANDI, 1'b1, ZLS | GRA | RE,  "andi_T5");
    add_fetch(IR_ORI, "ori");
    add(IR_ORI, 1'b1, GRB | RS | YE,    "ori_T3");
    add(IR_ORI, 1'b1, CS | ZE | ALU6,   "ori_T4");
    add(IR_ORI, 1'b1, ZLS | GRA | RE,   "ori_T5");
    add_fetch(IR_NOP, "nop");
    add(IR_NOP, 1'b1, NONE,             "nop_T3");
    add_fetch(IR_BAD, "bad");
    add(IR_BAD, 1'b1, ILL,              "bad_T3");
    add_fetch(IR_LD, "ld");
    add(IR_LD, 1'b1, GRB | BAO | YE,    "ld_T3");
    add(IR_LD, 1'b1, CS | ZE | ALU3,    "ld_T4");
    add(IR_LD, 1'b1, ZLS | MARE,        "ld_T5");
    add(IR_LD, 1'b1, RD | MDRE,         "ld_T6");
    add(IR_LD, 1'b1, MDRS | GRA | RE,   "ld_T7");
    add_fetch(IR_ST, "st");
    add(IR_ST, 1'b1, GRB | BAO | YE,    "st_T3");
    add(IR_ST, 1'b1, CS | ZE | ALU3,    "st_T4");
    add(IR_ST, 1'b1, ZLS | MARE,        "st_T5");
    add(IR_ST, 1'b1, GRA | RS | MDRE,   "st_T6");
    add(IR_ST, 1'b1, WR,                "st_T7");
    add_fetch(IR_HALT, "halt");
    add(IR_HALT, 1'b1, NONE,            "halt_T3");
    add(IR_HALT, 1'b1, HLT,             "halt_H0");
    add(IR_HALT, 1'b0, HLT,             "halt_H1");
    add(IR_NOP,  1'b1, HLT,             "halt_H2");

    IR_Data   = IR_LDI;
    mem_ready = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    exp_q.push_back(NONE);
    #1 check("reset_held");
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) step(vecs[i].ir, vecs[i].mr, vecs[i].exp, vecs[i].name);

    // ---- fetch stall: T1 held 4 cycles, PC increments only on the last ----
    do_reset();
    step(IR_NOP, 1'b1, E_T0,       "stall_T0");
    for (int k = 0; k < 3; k++)
      step(IR_NOP, 1'b0, RD | MDRE, "stall_T1_wait");
    step(IR_NOP, 1'b1, E_T1,       "stall_T1_done");
    step(IR_NOP, 1'b1, E_T2,       "stall_T2");
    step(IR_NOP, 1'b0, NONE,       "stall_nop_T3");
    step(IR_NOP, 1'b0, E_T0,       "stall_back_T0");
    step(IR_ST,  1'b1, E_T1,       "st2_T1");

    // ---- st with write stall; mem_ready low in T6 must be ignored ----
    step(IR_ST, 1'b1, E_T2,            "st2_T2");
    step(IR_ST, 1'b0, GRB | BAO | YE,  "st2_T3");
    step(IR_ST, 1'b0, CS | ZE | ALU3,  "st2_T4");
    step(IR_ST, 1'b0, ZLS | MARE,      "st2_T5");
    step(IR_ST, 1'b0, GRA | RS | MDRE, "st2_T6_no_read");
    step(IR_ST, 1'b0, WR,              "st2_T7_wait0");
    step(IR_ST, 1'b0, WR,              "st2_T7_wait1");
    step(IR_ST, 1'b1, WR,              "st2_T7_done");
    step(IR_LD, 1'b0, E_T0,            "st2_next_T0");

    // ---- asynchronous reset during ld T6 ----
    step(IR_LD, 1'b1, E_T1,            "ld2_T1");
    step(IR_LD, 1'b1, E_T2,            "ld2_T2");
    step(IR_LD, 1'b1, GRB | BAO | YE,  "ld2_T3");
    step(IR_LD, 1'b1, CS | ZE | ALU3,  "ld2_T4");
    step(IR_LD, 1'b1, ZLS | MARE,      "ld2_T5");
    step(IR_LD, 1'b0, RD | MDRE,       "ld2_T6_wait0");
    IR_Data   = IR_LD;
    mem_ready = 1'b0;
    #1;
    exp_q.push_back(RD | MDRE);
    check("ld2_T6_wait1");
    #1 reset = 1'b1;
    #1;
    exp_q.push_back(NONE);
    check("async_reset_zero");
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step(IR_NOP, 1'b1, E_T0,           "post_reset_T0");
    step(IR_NOP, 1'b1, E_T1,           "post_reset_T1");
    step(IR_NOP, 1'b1, E_T2,           "post_reset_T2");
    step(IR_NOP, 1'b1, NONE,           "post_reset_nop_T3");
    step(IR_NOP, 1'b1, E_T0,           "post_reset_T0b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
